// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm
// Control sequencer for the multi-cycle MIPS-subset datapath (R-type, ADDI,
// ORI, BEQ, LW, SW). Walks one instruction at a time through
// FETCH/DECODE/EXEC/MEM/WB, handshaking with variable-latency instruction and
// data memories. Illegal opcodes and memory timeouts park the FSM in TRAP
// until reset.
//
// Ports
//   clk_i, rst_i                     clock (rising edge), async active-high reset
//   instr_op_i                       opcode from the IR, sampled in DECODE
//   imem_ready_i / dmem_ready_i      memory handshakes (ignored outside FETCH/MEM)
//   imem_req_o, ir_write_o, pc_write_o, branch_o       fetch / PC control
//   ALU_src2_sel_o, ALU_op_o                            ALU control
//   reg_w1_addr_sel_o, reg_w1_data_sel_o, reg_write_o   register file control
//   DM_read_o, DM_write_o                               data memory strobes
//   instr_done_o, instr_count_o                         retire pulse / counter
//   trap_o, trap_cause_o, state_o                       status
module multicycle_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 16,  // 1..255
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [5:0]       instr_op_i,
  input  logic             imem_ready_i,
  input  logic             dmem_ready_i,
  output logic             imem_req_o,
  output logic             ir_write_o,
  output logic             pc_write_o,
  output logic             branch_o,
  output logic             ALU_src2_sel_o,
  output logic [5:0]       ALU_op_o,
  output logic             reg_w1_addr_sel_o,
  output logic             reg_w1_data_sel_o,
  output logic             reg_write_o,
  output logic             DM_read_o,
  output logic             DM_write_o,
  output logic             instr_done_o,
  output logic [CNT_W-1:0] instr_count_o,
  output logic             trap_o,
  output logic [1:0]       trap_cause_o,
  output logic [2:0]       state_o
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [1:0] C_ILLEGAL = 2'd1;
  localparam logic [1:0] C_IMEM_TO = 2'd2;
  localparam logic [1:0] C_DMEM_TO = 2'd3;

  localparam logic [8:0] TIMEOUT = 9'(MEM_TIMEOUT);

  state_t           state_q, state_d;
  logic [5:0]       op_q, op_d;
  logic [7:0]       wait_q, wait_d;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] cnt_q;
  logic             timeout;

  function automatic logic legal_op(input logic [5:0] op);
    return (op == OP_R) || (op == OP_BEQ) || (op == OP_ADDI) ||
           (op == OP_ORI) || (op == OP_LW) || (op == OP_SW);
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      wait_q  <= '0;
      cause_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wait_q  <= wait_d;
      cause_q <= cause_d;
      if (instr_done_o) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // This wait cycle would be the MEM_TIMEOUT-th one; a ready seen in the
  // same cycle takes priority over the trap.
  assign timeout = ({1'b0, wait_q} + 9'd1) == TIMEOUT;

  always_comb begin
    state_d           = state_q;
    op_d              = op_q;
    cause_d           = cause_q;
    wait_d            = '0;   // cleared on any state change
    imem_req_o        = 1'b0;
    ir_write_o        = 1'b0;
    pc_write_o        = 1'b0;
    branch_o          = 1'b0;
    ALU_src2_sel_o    = 1'b0;
    reg_w1_addr_sel_o = 1'b0;
    reg_w1_data_sel_o = 1'b0;
    reg_write_o       = 1'b0;
    DM_read_o         = 1'b0;
    DM_write_o        = 1'b0;
    instr_done_o      = 1'b0;

    case (state_q)
      S_FETCH: begin
        imem_req_o = 1'b1;
        if (imem_ready_i) begin
          ir_write_o = 1'b1;
          pc_write_o = 1'b1;
          state_d    = S_DECODE;
        end else if (timeout) begin
          state_d = S_TRAP;
          cause_d = C_IMEM_TO;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_DECODE: begin
        op_d = instr_op_i;
        if (legal_op(instr_op_i)) state_d = S_EXEC;
        else begin
          state_d = S_TRAP;
          cause_d = C_ILLEGAL;
        end
      end
      S_EXEC: begin
        ALU_src2_sel_o = (op_q == OP_ADDI) || (op_q == OP_ORI) ||
                         (op_q == OP_LW)   || (op_q == OP_SW);
        if (op_q == OP_BEQ) begin
          branch_o     = 1'b1;
          instr_done_o = 1'b1;
          state_d      = S_FETCH;
        end else if ((op_q == OP_LW) || (op_q == OP_SW)) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        // Immediate stays selected so the effective address holds steady.
        ALU_src2_sel_o = 1'b1;
        DM_read_o      = (op_q == OP_LW);
        DM_write_o     = (op_q == OP_SW);
        if (dmem_ready_i) begin
          if (op_q == OP_LW) state_d = S_WB;
          else begin
            instr_done_o = 1'b1;
            state_d      = S_FETCH;
          end
        end else if (timeout) begin
          state_d = S_TRAP;
          cause_d = C_DMEM_TO;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_WB: begin
        reg_write_o       = 1'b1;
        reg_w1_addr_sel_o = (op_q == OP_R);
        reg_w1_data_sel_o = (op_q == OP_LW);
        instr_done_o      = 1'b1;
        state_d           = S_FETCH;
      end
      S_TRAP: ;
      default: state_d = S_FETCH;
    endcase

    // Reset parks the FSM in FETCH; keep the fetch strobes quiet meanwhile.
    if (rst_i) begin
      imem_req_o = 1'b0;
      ir_write_o = 1'b0;
      pc_write_o = 1'b0;
    end
  end

  assign ALU_op_o      = op_q;
  assign instr_count_o = cnt_q;
  assign trap_o        = (state_q == S_TRAP);
  assign trap_cause_o  = cause_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
module tb_multicycle_ctrl_fsm;
  localparam int TO = 4;
  localparam int CW = 4;

  localparam logic [5:0] R = 6'h00, BEQ = 6'h04, ADDI = 6'h08,
                         ORI = 6'h0D, LW = 6'h23, SW = 6'h2B;

  // expected-flag bits, MSB..LSB matching the obs vector below
  localparam logic [10:0] IMEM = 11'h400, IRW = 11'h200, PCW = 11'h100,
                          BR = 11'h080, SRC2 = 11'h040, DMR = 11'h020,
                          DMW = 11'h010, RW = 11'h008, AS = 11'h004,
                          DS = 11'h002, DONE = 11'h001;

  logic          clk = 1'b0;
  logic          rst;
  logic [5:0]    op;
  logic          ir, dr;
  logic          imem_req, ir_write, pc_write, branch, src2;
  logic [5:0]    alu_op;
  logic          addr_sel, data_sel, reg_write, dm_read, dm_write, done;
  logic [CW-1:0] count;
  logic          trap;
  logic [1:0]    cause;
  logic [2:0]    state;
  logic [16:0]   obs;

  int n_chk = 0;
  int n_pass = 0;
  int exp_cnt = 0;

  multicycle_ctrl_fsm #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst), .instr_op_i(op),
    .imem_ready_i(ir), .dmem_ready_i(dr),
    .imem_req_o(imem_req), .ir_write_o(ir_write), .pc_write_o(pc_write),
    .branch_o(branch), .ALU_src2_sel_o(src2), .ALU_op_o(alu_op),
    .reg_w1_addr_sel_o(addr_sel), .reg_w1_data_sel_o(data_sel),
    .reg_write_o(reg_write), .DM_read_o(dm_read), .DM_write_o(dm_write),
    .instr_done_o(done), .instr_count_o(count), .trap_o(trap),
    .trap_cause_o(cause), .state_o(state)
  );

  always #5 clk = ~clk;

  assign obs = {state, trap, cause, imem_req, ir_write, pc_write, branch, src2,
                dm_read, dm_write, reg_write, addr_sel, data_sel, done};

  function automatic logic [16:0] ev(input int st, input int c, input logic [10:0] fl);
    return {3'(st), (st == 5), 2'(c), fl};
  endfunction

  function automatic bit legal(input logic [5:0] o);
    return o == R || o == BEQ || o == ADDI || o == ORI || o == LW || o == SW;
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] e);
    n_chk++;
    if (got !== e) $display("FAIL %s got=%h exp=%h", tag, got, e);
    else n_pass++;
  endtask

  // one clock cycle: drive after the falling edge, compare before the rising one
  task automatic cyc(input logic [5:0] o, input logic i, input logic d,
                     input logic [16:0] e, input string tag);
    @(negedge clk);
    op = o; ir = i; dr = d;
    #1 chk(tag, {15'b0, obs}, {15'b0, e});
  endtask

  task automatic done_tick();
    exp_cnt = (exp_cnt + 1) % (1 << CW);
    @(posedge clk);
    #1 chk("count", {28'b0, count}, 32'(exp_cnt));
  endtask

  task automatic trap_seq(input int c);
    for (int k = 0; k < 20; k++)
      cyc(6'($urandom), rb(), rb(), ev(5, c, 0), "trap_hold");
  endtask

  task automatic do_reset();
    @(negedge clk);
    op = 6'h0; ir = 1'b1; dr = 1'b1;
    #2 rst = 1'b1;
    #1 chk("rst_vec", {15'b0, obs}, {15'b0, ev(0, 0, 0)});
    chk("rst_alu", {26'b0, alu_op}, 32'h0);
    chk("rst_cnt", {28'b0, count}, 32'h0);
    exp_cnt = 0;
    @(posedge clk);
    #1 rst = 1'b0; ir = 1'b0; dr = 1'b0;
  endtask

  // Expected behaviour of one instruction, derived from its class:
  // iw / dw = ready-low cycles before the instruction / data memory answers.
  task automatic run_instr(input logic [5:0] o, input int iw, input int dw,
                           input bit abort, output bit ended_bad);
    bit imm;
    logic [10:0] strobe;
    ended_bad = 0;
    for (int k = 0; k <= iw; k++) begin
      if (k < iw) begin
        cyc(o, 1'b0, rb(), ev(0, 0, IMEM), "fetch_wait");
        if (k + 1 == TO) begin trap_seq(2); ended_bad = 1; return; end
      end else begin
        cyc(o, 1'b1, rb(), ev(0, 0, IMEM | IRW | PCW), "fetch_rdy");
      end
    end
    cyc(o, rb(), rb(), ev(1, 0, 0), "decode");
    if (!legal(o)) begin trap_seq(1); ended_bad = 1; return; end
    imm = (o == ADDI || o == ORI || o == LW || o == SW);
    if (o == BEQ) begin
      cyc(o, rb(), rb(), ev(2, 0, BR | DONE), "exec_beq");
      chk("alu_op", {26'b0, alu_op}, {26'b0, o});
      done_tick();
      return;
    end
    cyc(o, rb(), rb(), ev(2, 0, imm ? SRC2 : 11'h0), "exec");
    chk("alu_op", {26'b0, alu_op}, {26'b0, o});
    if (o == LW || o == SW) begin
      strobe = (o == LW) ? DMR : DMW;
      for (int k = 0; k <= dw; k++) begin
        if (k < dw) begin
          cyc(o, rb(), 1'b0, ev(3, 0, SRC2 | strobe), "mem_wait");
          if (abort) begin
            #1 rst = 1'b1;
            #1 chk("abort_vec", {15'b0, obs}, {15'b0, ev(0, 0, 0)});
            chk("abort_cnt", {28'b0, count}, 32'h0);
            exp_cnt = 0;
            @(posedge clk);
            #1 rst = 1'b0; ir = 1'b0; dr = 1'b0;
            cyc(o, 1'b0, 1'b0, ev(0, 0, IMEM), "after_abort");
            ended_bad = 1;
            return;
          end
          if (k + 1 == TO) begin trap_seq(3); ended_bad = 1; return; end
        end else begin
          cyc(o, rb(), 1'b1, ev(3, 0, SRC2 | strobe | ((o == SW) ? DONE : 11'h0)), "mem_rdy");
        end
      end
      if (o == SW) begin done_tick(); return; end
    end
    cyc(o, rb(), rb(),
        ev(4, 0, RW | ((o == R) ? AS : 11'h0) | ((o == LW) ? DS : 11'h0) | DONE), "wb");
    done_tick();
  endtask

  task automatic run(input logic [5:0] o, input int iw, input int dw, input bit abort);
    bit bad;
    run_instr(o, iw, dw, abort, bad);
    if (bad) do_reset();
  endtask

  initial begin
    logic [5:0] ops [6];
    ops = '{R, BEQ, ADDI, ORI, LW, SW};
    rst = 1'b1; op = 6'h0; ir = 1'b1; dr = 1'b1;
    repeat (2) @(negedge clk);
    #1 chk("reset_vec", {15'b0, obs}, {15'b0, ev(0, 0, 0)});
    chk("reset_alu", {26'b0, alu_op}, 32'h0);
    chk("reset_cnt", {28'b0, count}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0; ir = 1'b0; dr = 1'b0;

    run(R,     0, 0, 0);
    run(LW,    0, 3, 0);
    run(BEQ,   0, 0, 0);
    run(SW,    0, 4, 0);   // dmem timeout
    run(SW,    0, 3, 0);   // ready on the last allowed cycle
    run(6'h3F, 0, 0, 0);   // illegal
    run(ADDI,  4, 0, 0);   // imem timeout
    run(ORI,   3, 0, 0);
    run(LW,    1, 2, 1);   // reset mid-MEM
    for (int n = 0; n < 17; n++) run(ADDI, 0, 0, 0);
    chk("wrap", {28'b0, count}, 32'd1);

    for (int n = 0; n < 60; n++) begin
      logic [5:0] o;
      int iw, dw;
      o  = ($urandom % 10 == 0) ? 6'($urandom) : ops[$urandom % 6];
      iw = ($urandom % 8 == 0) ? TO : int'($urandom_range(0, 2));
      dw = ($urandom % 8 == 0) ? TO : int'($urandom_range(0, TO - 1));
      run(o, iw, dw, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
